mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 2, meaning SRAM access length in clock cycles (legal 1..15).
REQ-002 SHALL have port CLK  in  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports if_req in 1, if_addr in 16: instruction-fetch read request and word address.
REQ-005 SHALL have ports if_ack out 1, if_rdata out 16: one-cycle fetch completion pulse and fetched word.
REQ-006 SHALL have ports mem_req in 1, mem_we in 1, mem_addr in 16, mem_wdata in 16: MEM-stage load (mem_we=0) or store (mem_we=1) request.
REQ-007 SHALL have ports mem_ack out 1, mem_rdata out 16: one-cycle MEM completion pulse and load data.
REQ-008 SHALL have ports ram_ce out 1, ram_we out 1, ram_addr out 16, ram_wdata out 16, ram_rdata in 16: shared single-port SRAM.
REQ-009 SHALL have ports stall_o out 1 (freeze PC and IF/ID..EX/MEM registers) and busy_o out 1 (access in progress).

Function
REQ-010 SHALL implement states IDLE, MEM_ACC, IF_ACC, DONE.
REQ-011 IDLE: mem_req=1 -> latch mem_we/addr/wdata, go MEM_ACC; else if_req=1 -> latch if_addr, go IF_ACC; else stay.
REQ-012 MEM SHALL have fixed priority over IF when both are high in the same IDLE cycle.
REQ-013 MEM_ACC/IF_ACC SHALL last exactly ACCESS_CYCLES cycles, counted by a 4-bit counter loaded at grant; then go DONE.
REQ-014 During MEM_ACC/IF_ACC: ram_ce=1, ram_addr/ram_wdata = latched values, ram_we = latched mem_we (always 0 for IF); all held stable for every access cycle.
REQ-015 Outside MEM_ACC/IF_ACC: ram_ce=0, ram_we=0; ram_addr/ram_wdata hold their last values.
REQ-016 ram_rdata SHALL be sampled at the end of the last access cycle, into mem_rdata (MEM load) or if_rdata (IF).
REQ-017 DONE SHALL last one cycle, asserting exactly one of mem_ack/if_ack for the completed owner; no grant in DONE; next state IDLE.
REQ-018 Request-to-ack latency SHALL be ACCESS_CYCLES+2 cycles from the IDLE cycle where req is high.
REQ-019 mem_rdata/if_rdata SHALL hold their value until overwritten by the next access of the same port; a store SHALL NOT change mem_rdata.
REQ-020 Requesters hold req and operands until ack; the arbiter ignores operand changes after grant.
REQ-021 busy_o SHALL equal 1 in MEM_ACC, IF_ACC and DONE.
REQ-022 stall_o SHALL equal (if_req & ~if_ack) | (mem_req & ~mem_ack), combinationally.
REQ-023 A request that drops before grant SHALL be discarded with no SRAM activity; a drop after grant SHALL NOT abort the access.
REQ-024 Back-to-back: a req still high in the cycle after DONE SHALL be granted as a new request (priority rule applies).

Reset
REQ-025 RST=1 at a clock edge SHALL force IDLE, counter 0, ram_ce=0, ram_we=0, ram_addr=0, ram_wdata=0, if_rdata=0, mem_rdata=0, latched request cleared.
REQ-026 RST asserted mid-access SHALL abort it: no ack is issued, and any store in flight ends with ram_we=0 from the next cycle.
REQ-027 After RST deasserts, the first grant SHALL occur no earlier than the first IDLE cycle with RST=0.

Verification
REQ-028 IF read, ACCESS_CYCLES=2, if_addr=0x0010, ram_rdata=0x4A21 -> ram_ce high 2 cycles, if_ack at cycle +4, if_rdata=0x4A21.
REQ-029 Simultaneous if_req (0x0011) and mem_req load 0x8000 -> MEM served first, mem_ack at +4; IF granted at +5, if_ack at +8; stall_o high throughout.
REQ-030 Store mem_addr=0x8002, wdata=0xBEEF -> ram_we=1 and ram_wdata=0xBEEF for both access cycles; mem_ack at +4; mem_rdata unchanged.
REQ-031 RST pulsed during the second cycle of a store -> ram_we=0 next cycle, no mem_ack, all outputs at reset values.
REQ-032 ACCESS_CYCLES=1 vs 15 sweep -> ack latency 3 and 17 cycles; counter wraps correctly; no missed or double acks.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared single-port SRAM arbiter, MEM-stage priority over instruction fetch
module mem_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [15:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic        mem_ack,
    output logic [15:0] mem_rdata,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        stall_o,
    output logic        busy_o
);

    localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_ACC = 2'd1,
        IF_ACC  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        owner_mem_q, owner_mem_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] mem_rdata_q, mem_rdata_d;
    logic        in_access;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            owner_mem_q <= 1'b0;
            if_rdata_q  <= 16'h0000;
            mem_rdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_mem_q <= owner_mem_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        owner_mem_d = owner_mem_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    state_d     = MEM_ACC;
                    cnt_d       = ACC_LOAD;
                    we_d        = mem_we;
                    addr_d      = mem_addr;
                    wdata_d     = mem_wdata;
                    owner_mem_d = 1'b1;
                end else if (if_req) begin
                    // A fetch leaves the write-data register untouched.
                    state_d     = IF_ACC;
                    cnt_d       = ACC_LOAD;
                    we_d        = 1'b0;
                    addr_d      = if_addr;
                    owner_mem_d = 1'b0;
                end
            end
            MEM_ACC, IF_ACC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                    if (state_q == IF_ACC) begin
                        if_rdata_d = ram_rdata;
                    end else if (!we_q) begin
                        mem_rdata_d = ram_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_access = (state_q == MEM_ACC) || (state_q == IF_ACC);

    assign ram_ce    = in_access;
    assign ram_we    = in_access && we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

    assign mem_ack   = (state_q == DONE) && owner_mem_q;
    assign if_ack    = (state_q == DONE) && !owner_mem_q;
    assign mem_rdata = mem_rdata_q;
    assign if_rdata  = if_rdata_q;

    assign busy_o    = (state_q != IDLE);
    assign stall_o   = (if_req & ~if_ack) | (mem_req & ~mem_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized transaction-timeline checks of mem_arbiter at ACCESS_CYCLES 2, 1 and 15
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        if_req    [3];
    logic [15:0] if_addr   [3];
    logic        if_ack    [3];
    logic [15:0] if_rdata  [3];
    logic        mem_req   [3];
    logic        mem_we    [3];
    logic [15:0] mem_addr  [3];
    logic [15:0] mem_wdata [3];
    logic        mem_ack   [3];
    logic [15:0] mem_rdata [3];
    logic        ram_ce    [3];
    logic        ram_we    [3];
    logic [15:0] ram_addr  [3];
    logic [15:0] ram_wdata [3];
    logic [15:0] ram_rdata [3];
    logic        stall_o   [3];
    logic        busy_o    [3];

    logic [15:0] sram    [3][65536];
    bit          written [3][65536];
    logic [15:0] ref_wr  [int];
    logic [15:0] exp_addr [3];
    logic [15:0] exp_wdata [3];
    logic [15:0] exp_if_rd [3];
    logic [15:0] exp_mem_rd [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    function automatic logic [15:0] hash16(input logic [15:0] a);
        logic [31:0] p;
        p = {16'h0000, a} * 32'd40503;
        return p[15:0] ^ 16'h5A5A;
    endfunction

    function automatic int ac_of(input int idx);
        return (idx == 0) ? 2 : ((idx == 1) ? 1 : 15);
    endfunction

    function automatic int key_of(input int idx, input logic [15:0] a);
        return idx * 65536 + int'(a);
    endfunction

    function automatic logic [15:0] ref_rd(input int idx, input logic [15:0] a);
        int k;
        k = key_of(idx, a);
        return ref_wr.exists(k) ? ref_wr[k] : hash16(a);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_arbiter #(
            .ACCESS_CYCLES((g == 0) ? 2 : ((g == 1) ? 1 : 15))
        ) u_dut (
            .CLK       (CLK),
            .RST       (RST),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_ack    (if_ack[g]),
            .if_rdata  (if_rdata[g]),
            .mem_req   (mem_req[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_ack   (mem_ack[g]),
            .mem_rdata (mem_rdata[g]),
            .ram_ce    (ram_ce[g]),
            .ram_we    (ram_we[g]),
            .ram_addr  (ram_addr[g]),
            .ram_wdata (ram_wdata[g]),
            .ram_rdata (ram_rdata[g]),
            .stall_o   (stall_o[g]),
            .busy_o    (busy_o[g])
        );
        assign ram_rdata[g] = written[g][ram_addr[g]] ? sram[g][ram_addr[g]] : hash16(ram_addr[g]);
    end

    // Bench-side SRAM; unwritten words read as a fixed address hash.
    always @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (ram_ce[i] && ram_we[i]) begin
                sram[i][ram_addr[i]]    <= ram_wdata[i];
                written[i][ram_addr[i]] <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input int idx, input string tag);
        chk($sformatf("%s d%0d ce", tag, idx), ram_ce[idx], 0);
        chk($sformatf("%s d%0d we", tag, idx), ram_we[idx], 0);
        chk($sformatf("%s d%0d addr", tag, idx), ram_addr[idx], 0);
        chk($sformatf("%s d%0d wdata", tag, idx), ram_wdata[idx], 0);
        chk($sformatf("%s d%0d mack", tag, idx), mem_ack[idx], 0);
        chk($sformatf("%s d%0d iack", tag, idx), if_ack[idx], 0);
        chk($sformatf("%s d%0d busy", tag, idx), busy_o[idx], 0);
        chk($sformatf("%s d%0d mrd", tag, idx), mem_rdata[idx], 0);
        chk($sformatf("%s d%0d ird", tag, idx), if_rdata[idx], 0);
        exp_addr[idx]   = 16'h0000;
        exp_wdata[idx]  = 16'h0000;
        exp_if_rd[idx]  = 16'h0000;
        exp_mem_rd[idx] = 16'h0000;
    endtask

    // mode: 0 IF, 1 load, 2 store, 3 MEM+IF together, 4 MEM+IF with IF dropped before grant,
    // 5 MEM then MEM back-to-back (req held, new operands after first ack).
    task automatic run_txn(input int idx, input int mode,
                           input logic m_we, input logic [15:0] m_addr, input logic [15:0] m_wdata,
                           input logic [15:0] i_addr,
                           input logic m2_we, input logic [15:0] m2_addr, input logic [15:0] m2_wdata);
        int   ac, l1, l2, last;
        bit   first_mem, second, second_mem, in1, in2;
        logic exp_we, exp_mack, exp_iack, exp_busy, exp_stall;
        string t;
        ac         = ac_of(idx);
        first_mem  = (mode != 0);
        second     = (mode == 3) || (mode == 5);
        second_mem = (mode == 5);
        l1         = ac + 2;
        l2         = 2 * ac + 4;
        last       = second ? l2 + 1 : l1 + 1;
        for (int c = 1; c <= last; c++) begin
            if (c == 1) begin
                mem_we[idx] = m_we; mem_addr[idx] = m_addr; mem_wdata[idx] = m_wdata;
                if_addr[idx] = i_addr;
            end
            if (c == 2) begin
                mem_we[idx] = 1'($urandom); mem_addr[idx] = 16'($urandom); mem_wdata[idx] = 16'($urandom);
                if (mode == 0) if_addr[idx] = 16'($urandom);
            end
            if (mode == 5 && c == ac + 3) begin
                mem_we[idx] = m2_we; mem_addr[idx] = m2_addr; mem_wdata[idx] = m2_wdata;
            end
            if (mode == 5 && c == ac + 4) begin
                mem_addr[idx] = 16'($urandom); mem_wdata[idx] = 16'($urandom);
            end
            mem_req[idx] = (mode >= 1 && mode <= 4) ? (c <= l1) : ((mode == 5) ? (c <= l2) : 1'b0);
            if_req[idx]  = (mode == 0) ? (c <= l1) : ((mode == 3) ? (c <= l2) : ((mode == 4) ? (c == 1) : 1'b0));

            in1 = (c >= 2) && (c <= ac + 1);
            in2 = second && (c >= ac + 4) && (c <= 2 * ac + 3);
            if (c == 2) begin
                if (first_mem) begin exp_addr[idx] = m_addr; exp_wdata[idx] = m_wdata; end
                else exp_addr[idx] = i_addr;
            end
            if (second && c == ac + 4) begin
                if (second_mem) begin exp_addr[idx] = m2_addr; exp_wdata[idx] = m2_wdata; end
                else exp_addr[idx] = i_addr;
            end
            exp_we   = (in1 && first_mem && m_we) || (in2 && second_mem && m2_we);
            exp_mack = (c == l1 && first_mem) || (c == l2 && second_mem);
            exp_iack = (c == l1 && !first_mem) || (c == l2 && second && !second_mem);
            exp_busy = (c >= 2 && c <= l1) || (second && c >= ac + 4 && c <= l2);
            if (c == l1) begin
                if (!first_mem) exp_if_rd[idx] = ref_rd(idx, i_addr);
                else if (!m_we) exp_mem_rd[idx] = ref_rd(idx, m_addr);
                else ref_wr[key_of(idx, m_addr)] = m_wdata;
            end
            if (second && c == l2) begin
                if (!second_mem) exp_if_rd[idx] = ref_rd(idx, i_addr);
                else if (!m2_we) exp_mem_rd[idx] = ref_rd(idx, m2_addr);
                else ref_wr[key_of(idx, m2_addr)] = m2_wdata;
            end
            exp_stall = (if_req[idx] & ~exp_iack) | (mem_req[idx] & ~exp_mack);
            #1;
            t = $sformatf("d%0d m%0d c%0d", idx, mode, c);
            chk({t, " ce"}, ram_ce[idx], in1 || in2);
            chk({t, " we"}, ram_we[idx], exp_we);
            chk({t, " addr"}, ram_addr[idx], exp_addr[idx]);
            chk({t, " wdata"}, ram_wdata[idx], exp_wdata[idx]);
            chk({t, " mack"}, mem_ack[idx], exp_mack);
            chk({t, " iack"}, if_ack[idx], exp_iack);
            chk({t, " busy"}, busy_o[idx], exp_busy);
            chk({t, " stall"}, stall_o[idx], exp_stall);
            chk({t, " mrd"}, mem_rdata[idx], exp_mem_rd[idx]);
            chk({t, " ird"}, if_rdata[idx], exp_if_rd[idx]);
            @(negedge CLK);
        end
    endtask

    task automatic reset_mid_store();
        mem_req[0] = 1'b1; mem_we[0] = 1'b1; mem_addr[0] = 16'h8004; mem_wdata[0] = 16'h1357;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk("rst pre we", ram_we[0], 1);
        RST = 1'b1;
        @(negedge CLK);
        #1;
        for (int i = 0; i < 3; i++) chk_reset(i, "rst mid");
        ref_wr[key_of(0, 16'h8004)] = 16'h1357;
        @(negedge CLK);
        #1;
        chk("rst held busy", busy_o[0], 0);
        chk("rst held ce", ram_ce[0], 0);
        chk("rst held mack", mem_ack[0], 0);
        RST = 1'b0;
        run_txn(0, 2, 1'b1, 16'h8006, 16'h2468, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    endtask

    function automatic logic [15:0] rnd_addr();
        return 16'($urandom_range(0, 7)) | (($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000);
    endfunction

    initial begin
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_req[i] = 1'b0; if_addr[i] = 16'h0000;
            mem_req[i] = 1'b0; mem_we[i] = 1'b0; mem_addr[i] = 16'h0000; mem_wdata[i] = 16'h0000;
        end
        repeat (2) @(negedge CLK);
        #1;
        for (int i = 0; i < 3; i++) chk_reset(i, "por");
        RST = 1'b0;
        @(negedge CLK);

        run_txn(0, 2, 1'b1, 16'h0010, 16'h4A21, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        run_txn(0, 0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 1'b0, 16'h0000, 16'h0000);
        chk("fetch 0x0010 word", if_rdata[0], 16'h4A21);
        run_txn(0, 3, 1'b0, 16'h8000, 16'h0000, 16'h0011, 1'b0, 16'h0000, 16'h0000);
        run_txn(0, 2, 1'b1, 16'h8002, 16'hBEEF, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        run_txn(0, 5, 1'b1, 16'h8003, 16'hCAFE, 16'h0000, 1'b0, 16'h8003, 16'h0000);
        chk("b2b load after store", mem_rdata[0], 16'hCAFE);
        reset_mid_store();

        for (int i = 1; i < 3; i++) begin
            run_txn(i, 1, 1'b0, 16'h8001, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
            run_txn(i, 0, 1'b0, 16'h0000, 16'h0000, 16'h0005, 1'b0, 16'h0000, 16'h0000);
            run_txn(i, 3, 1'b1, 16'h0006, 16'h7777, 16'h0006, 1'b0, 16'h0000, 16'h0000);
            chk($sformatf("d%0d fetch after store", i), if_rdata[i], 16'h7777);
            run_txn(i, 4, 1'b0, 16'h0002, 16'h0000, 16'h0003, 1'b0, 16'h0000, 16'h0000);
            run_txn(i, 5, 1'b0, 16'h0001, 16'h0000, 16'h0000, 1'b1, 16'h0001, 16'h5555);
        end

        for (int n = 0; n < 60; n++) begin
            run_txn($urandom_range(0, 2), $urandom_range(0, 5),
                    1'($urandom), rnd_addr(), 16'($urandom), rnd_addr(),
                    1'($urandom), rnd_addr(), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
